rf2_32x128_wm1_ctrl: RTL and testbench

- Request-side controller that sits directly upstream of the rf2_32x128_wm1 two-port SRAM macro (32 x 128, per-bit write mask; port A read-only, port B write-only).
- Converts valid/ready write and read requests into the macro's active-low CENA/CENB/WENB controls.
- Forwards same-cycle same-address write data into read responses, since the controller never relies on macro collision behaviour.
- Buffers read data in a small response FIFO so consumers may apply backpressure.

---
 rtl/rf2_32x128_wm1_ctrl.sv | 113 +++++++++++
 tb/tb_rf2_32x128_wm1_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf2_32x128_wm1_ctrl.sv
// Request-side controller for the rf2_32x128_wm1 two-port SRAM macro.
// Write/read handshakes, same-cycle write forwarding, read response FIFO.
module rf2_32x128_wm1_ctrl #(
  parameter int RSP_DEPTH = 3,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [4:0]   wr_addr,
  input  logic [15:0]  wr_byteen,
  input  logic [127:0] wr_data,
  input  logic         rd_req_valid,
  output logic         rd_req_ready,
  input  logic [4:0]   rd_req_addr,
  output logic         rd_rsp_valid,
  input  logic         rd_rsp_ready,
  output logic [127:0] rd_rsp_data,
  output logic         mem_cena,
  output logic [4:0]   mem_aa,
  input  logic [127:0] mem_qa,
  output logic         mem_cenb,
  output logic [127:0] mem_wenb,
  output logic [4:0]   mem_ab,
  output logic [127:0] mem_db
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(RSP_DEPTH);

  logic           wr_fire;
  logic           rd_fire;
  logic [127:0]   wmask;
  logic           pend_valid;
  logic           pend_coll;
  logic [127:0]   byp_data;
  logic [127:0]   byp_mask;
  logic [127:0]   rdata;
  logic [127:0]   fifo [RSP_DEPTH];
  logic [PW-1:0]  rptr;
  logic [PW-1:0]  wptr;
  logic [CW-1:0]  count;
  logic [CW:0]    occ;
  logic           push;
  logic           pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wmask = '0;
    for (int i = 0; i < 128; i++) begin
      wmask[i] = wr_byteen[i/8];
    end
  end

  assign wr_ready = ~reset;
  assign wr_fire  = wr_valid & wr_ready;
  assign mem_cenb = ~wr_fire;
  assign mem_ab   = wr_fire ? wr_addr : '0;
  assign mem_db   = wr_fire ? wr_data : '0;
  assign mem_wenb = ~(wr_fire ? wmask : '0);

  // Occupancy counts the read still inside the macro so the FIFO can't overflow.
  assign occ          = {1'b0, count} + (CW + 1)'(pend_valid);
  assign rd_req_ready = ~reset & (occ < DEPTH_L);
  assign rd_fire      = rd_req_valid & rd_req_ready;
  assign mem_cena     = ~rd_fire;
  assign mem_aa       = rd_fire ? rd_req_addr : '0;

  assign rdata = pend_coll ? ((mem_qa & ~byp_mask) | (byp_data & byp_mask))
                           : mem_qa;

  assign push         = pend_valid;
  assign rd_rsp_valid = ~reset & (count != '0);
  assign pop          = rd_rsp_valid & rd_rsp_ready;
  assign rd_rsp_data  = (count != '0) ? fifo[rptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_coll  <= 1'b0;
      byp_data   <= '0;
      byp_mask   <= '0;
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
    end else begin
      pend_valid <= rd_fire;
      if (rd_fire) begin
        pend_coll <= BYPASS_EN & wr_fire & (wr_addr == rd_req_addr);
        byp_data  <= wr_data;
        byp_mask  <= wmask;
      end
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo[wptr] <= rdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && !pop && count == CW'(RSP_DEPTH)));
  end

endmodule

// File: tb/tb_rf2_32x128_wm1_ctrl.sv
// Bench for rf2_32x128_wm1_ctrl with an SRAM macro model and a
// row-level reference model of read results and response timing.
module tb_rf2_32x128_wm1_ctrl;

  localparam int DEPTH = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_valid;
  logic         wr_ready;
  logic [4:0]   wr_addr;
  logic [15:0]  wr_byteen;
  logic [127:0] wr_data;
  logic         rd_req_valid;
  logic         rd_req_ready;
  logic [4:0]   rd_req_addr;
  logic         rd_rsp_valid;
  logic         rd_rsp_ready;
  logic [127:0] rd_rsp_data;
  logic         mem_cena;
  logic [4:0]   mem_aa;
  logic [127:0] mem_qa = '0;
  logic         mem_cenb;
  logic [127:0] mem_wenb;
  logic [4:0]   mem_ab;
  logic [127:0] mem_db;

  rf2_32x128_wm1_ctrl #(.RSP_DEPTH(DEPTH), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_byteen(wr_byteen), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_data(rd_rsp_data),
    .mem_cena(mem_cena), .mem_aa(mem_aa), .mem_qa(mem_qa),
    .mem_cenb(mem_cenb), .mem_wenb(mem_wenb), .mem_ab(mem_ab),
    .mem_db(mem_db)
  );

  always #5 clk = ~clk;

  // Macro: read returns pre-write contents on a same-row collision.
  logic [127:0] arr [32] = '{default: '0};
  always @(posedge clk) begin
    if (!mem_cena) mem_qa <= arr[mem_aa];
    if (!mem_cenb)
      arr[mem_ab] <= (arr[mem_ab] & mem_wenb) | (mem_db & ~mem_wenb);
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [127:0] rmem [32] = '{default: '0};
  logic [127:0] q_d [$];
  int           q_t [$];
  logic         last_rf;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic wf, rf, ev;
    logic [127:0] m, row;
    @(negedge clk);
    wf = wr_valid && !reset;
    ev = !reset && q_d.size() > 0 && q_t[0] <= cyc;
    rf = rd_req_valid && !reset && (q_d.size() < DEPTH);
    for (int i = 0; i < 128; i++) m[i] = wf && wr_byteen[i/8];
    chk("wr_ready", 128'(wr_ready), 128'(!reset));
    chk("rd_req_ready", 128'(rd_req_ready),
        128'(!reset && q_d.size() < DEPTH));
    chk("rd_rsp_valid", 128'(rd_rsp_valid), 128'(ev));
    if (!reset) chk("rd_rsp_data", rd_rsp_data, ev ? q_d[0] : '0);
    chk("mem_cena", 128'(mem_cena), 128'(!rf));
    chk("mem_aa", 128'(mem_aa), rf ? 128'(rd_req_addr) : '0);
    chk("mem_cenb", 128'(mem_cenb), 128'(!wf));
    chk("mem_ab", 128'(mem_ab), wf ? 128'(wr_addr) : '0);
    chk("mem_db", mem_db, wf ? wr_data : '0);
    chk("mem_wenb", mem_wenb, ~m);
    if (ev && rd_rsp_ready) begin
      void'(q_d.pop_front());
      void'(q_t.pop_front());
    end
    if (rf) begin
      row = rmem[rd_req_addr];
      if (wf && wr_addr == rd_req_addr) row = (row & ~m) | (wr_data & m);
      q_d.push_back(row);
      q_t.push_back(cyc + 2);
    end
    if (wf) rmem[wr_addr] = (rmem[wr_addr] & ~m) | (wr_data & m);
    last_rf = rf;
    @(posedge clk);
    if (reset) begin
      q_d.delete();
      q_t.delete();
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    wr_valid = 1'b0;
    rd_req_valid = 1'b0;
    rd_rsp_ready = 1'b1;
    for (int k = 0; k < 20 && q_d.size() > 0; k++) step();
    chk("drain_empty", 128'(q_d.size()), '0);
  endtask

  initial begin
    int nx;
    int fires;
    reset = 1'b1;
    wr_valid = 1'b1;
    wr_addr = 5'd3;
    wr_byteen = 16'hFFFF;
    wr_data = '1;
    rd_req_valid = 1'b1;
    rd_req_addr = 5'd3;
    rd_rsp_ready = 1'b1;
    #1;
    repeat (3) step();

    reset = 1'b0;
    wr_valid = 1'b0;
    rd_req_valid = 1'b0;
    step();

    // Masked write then readback
    wr_valid = 1'b1;
    wr_addr = 5'h0a;
    wr_byteen = 16'hFFFF;
    wr_data = '1;
    step();
    wr_byteen = 16'hFFF0;
    wr_data = 128'h0000_0002_0000_0002_0000_0002_0000_0002;
    #1;
    chk("masked_wenb", mem_wenb, {96'b0, 32'hFFFF_FFFF});
    step();
    wr_valid = 1'b0;
    rd_req_valid = 1'b1;
    rd_req_addr = 5'h0a;
    step();
    rd_req_valid = 1'b0;
    step();
    chk("readback_valid", 128'(rd_rsp_valid), 128'(1));
    chk("readback_data", rd_rsp_data,
        128'h0000_0002_0000_0002_0000_0002_FFFF_FFFF);
    drain();

    // Same-cycle collision on row 5
    wr_valid = 1'b1;
    wr_addr = 5'd5;
    wr_byteen = 16'h00FF;
    wr_data = '1;
    rd_req_valid = 1'b1;
    rd_req_addr = 5'd5;
    step();
    wr_valid = 1'b0;
    rd_req_valid = 1'b0;
    step();
    chk("coll_data", rd_rsp_data,
        128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
    drain();

    // Backpressure with rows 0..4
    rd_rsp_ready = 1'b0;
    nx = 0;
    for (int k = 0; k < 5; k++) begin
      rd_req_valid = 1'b1;
      rd_req_addr = 5'(nx);
      step();
      if (last_rf) nx++;
    end
    chk("bp_accepted", 128'(nx), 128'(3));
    chk("bp_ready_low", 128'(rd_req_ready), '0);
    rd_rsp_ready = 1'b1;
    for (int k = 0; k < 20 && nx < 5; k++) begin
      rd_req_addr = 5'(nx);
      step();
      if (last_rf) nx++;
    end
    chk("bp_all_accepted", 128'(nx), 128'(5));
    drain();

    // Full-rate reads of all rows
    fires = 0;
    for (int k = 0; k < 32; k++) begin
      rd_req_valid = 1'b1;
      rd_req_addr = 5'(k);
      step();
      if (last_rf) fires++;
    end
    chk("tput_fires", 128'(fires), 128'(32));
    drain();

    // Reset with two buffered responses and one in flight
    rd_rsp_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      rd_req_valid = 1'b1;
      rd_req_addr = 5'(k);
      step();
    end
    rd_req_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_rsp_ready = 1'b1;
    repeat (4) step();
    rd_req_valid = 1'b1;
    rd_req_addr = 5'h0a;
    step();
    rd_req_valid = 1'b0;
    step();
    chk("post_reset_data", rd_rsp_data,
        128'h0000_0002_0000_0002_0000_0002_FFFF_FFFF);
    drain();

    // Random traffic concentrated on a few rows to force collisions
    for (int k = 0; k < 400; k++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom_range(0, 7));
      wr_byteen = 16'($urandom);
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      rd_req_valid = 1'($urandom_range(0, 1));
      rd_req_addr = 5'($urandom_range(0, 7));
      rd_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
